// File: rtl/alien_pixel_fetch.sv
// Three-stage sprite fetch: register and guard the renderer request, read the
// synchronous sprite ROM, then resolve transparency and count opaque pixels per frame.
module alien_pixel_fetch #(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  deriv_select,
  input  logic [15:0] pixel_addr,
  input  logic        frame_start,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel_out,
  output logic        pixel_valid,
  output logic [15:0] frame_opaque
);

  localparam logic [16:0] LP_FRAME_WORDS = 17'(FRAME_WORDS);

  logic        w_in_range;
  logic        w_s1_accept;
  logic        w_opaque;
  logic        r_s1_valid;
  logic        r_s1_fs;
  logic        r_s2_valid;
  logic        r_s2_fs;
  logic [15:0] r_opaque_cnt;

  // Addresses past the frame come from renderer underflow wrap and must not reach the ROM.
  assign w_in_range  = ({1'b0, pixel_addr} < LP_FRAME_WORDS);
  assign w_s1_accept = in_valid & w_in_range;
  assign w_opaque    = r_s2_valid & (rom_data != TRANSPARENT);

  // Stage S1: capture request flags and drive the ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_fs    <= 1'b0;
      rom_addr   <= 12'h000;
    end else begin
      r_s1_valid <= w_s1_accept;
      r_s1_fs    <= frame_start;
      if (w_s1_accept) begin
        rom_addr <= {deriv_select, pixel_addr[9:0]};
      end else begin
        rom_addr <= rom_addr;
      end
    end
  end

  // Stage S2: flags ride alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_fs    <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_fs    <= r_s1_fs;
    end
  end

  // Stage S3: resolve transparency into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      pixel_out   <= 12'h000;
    end else begin
      pixel_valid <= w_opaque;
      pixel_out   <= w_opaque ? rom_data : 12'h000;
    end
  end

  // Per-frame opaque counter; a pixel coincident with frame_start opens the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opaque_cnt <= 16'h0000;
      frame_opaque <= 16'h0000;
    end else if (r_s2_fs) begin
      frame_opaque <= r_opaque_cnt;
      r_opaque_cnt <= w_opaque ? 16'h0001 : 16'h0000;
    end else begin
      frame_opaque <= frame_opaque;
      if (w_opaque && (r_opaque_cnt != 16'hFFFF)) begin
        r_opaque_cnt <= r_opaque_cnt + 16'h0001;
      end else begin
        r_opaque_cnt <= r_opaque_cnt;
      end
    end
  end

endmodule

// File: tb/tb_alien_pixel_fetch.sv
// Directed bench for alien_pixel_fetch: behavioural ROM, a queue of expected
// outputs filled as pixels are driven and drained three cycles later.
module tb_alien_pixel_fetch;

  typedef struct packed {
    logic        pv;
    logic [11:0] po;
    logic [15:0] fo;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  deriv_select;
  logic [15:0] pixel_addr;
  logic        frame_start;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] pixel_out;
  logic        pixel_valid;
  logic [15:0] frame_opaque;

  logic [11:0] rom_mem [4096];
  exp_t        exp_q[$];
  logic [15:0] m_cnt;
  logic [15:0] m_fo;
  logic [11:0] m_rom_addr;
  int          checks;
  int          failures;

  alien_pixel_fetch #(.FRAME_WORDS(1024), .TRANSPARENT(12'h000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .deriv_select(deriv_select),
    .pixel_addr(pixel_addr), .frame_start(frame_start), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .frame_opaque(frame_opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sprite ROM: one clock of read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] d,
                      input logic [15:0] a, input logic fs);
    logic        acc;
    logic        op;
    logic [11:0] data;
    exp_t        e;
    exp_t        z;
    @(negedge clk);
    rst = r; in_valid = v; deriv_select = d; pixel_addr = a; frame_start = fs;
    if (!r) begin
      acc  = v && (a < 16'd1024);
      data = rom_mem[{d, a[9:0]}];
      op   = acc && (data != 12'h000);
      if (acc) m_rom_addr = {d, a[9:0]};
      if (fs) begin
        m_fo  = m_cnt;
        m_cnt = op ? 16'd1 : 16'd0;
      end else if (op && m_cnt != 16'hFFFF) begin
        m_cnt = m_cnt + 16'd1;
      end
      e.pv = op; e.po = op ? data : 12'h000; e.fo = m_fo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 16'd0; m_fo = 16'd0; m_rom_addr = 12'h000;
      z.pv = 1'b0; z.po = 12'h000; z.fo = 16'd0;
      exp_q.delete();
      exp_q.push_back(z);
      exp_q.push_back(z);
      chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
      chk("rst_pixel_out", {20'd0, pixel_out}, 32'd0);
      chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
      chk("rst_frame_opaque", {16'd0, frame_opaque}, 32'd0);
    end else begin
      chk("rom_addr", {20'd0, rom_addr}, {20'd0, m_rom_addr});
      if (exp_q.size() >= 3) begin
        e = exp_q.pop_front();
        chk("pixel_valid", {31'd0, pixel_valid}, {31'd0, e.pv});
        chk("pixel_out", {20'd0, pixel_out}, {20'd0, e.po});
        chk("frame_opaque", {16'd0, frame_opaque}, {16'd0, e.fo});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 16'd0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_cnt = 16'd0; m_fo = 16'd0; m_rom_addr = 12'h000;
    rst = 1'b1; in_valid = 1'b0; deriv_select = 2'd0; pixel_addr = 16'd0; frame_start = 1'b0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 12'(i) ^ 12'hA5A;
    rom_mem[12'h805] = 12'hF0F;
    rom_mem[12'h40A] = 12'h123;
    rom_mem[12'h40B] = 12'h456;
    rom_mem[12'h40C] = 12'h000;
    rom_mem[12'h40D] = 12'h789;
    for (int i = 100; i < 110; i++) rom_mem[i] = 12'h111;
    for (int i = 110; i < 113; i++) rom_mem[i] = 12'h000;
    for (int i = 12'hC00; i < 4096; i++) rom_mem[i] = 12'hABC;

    step(1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 16'd0, 1'b0);
    idle(3);

    // Basic fetch
    step(1'b0, 1'b1, 2'd2, 16'd5, 1'b0);
    chk("basic_rom_addr", {20'd0, rom_addr}, 32'h805);
    idle(2);
    chk("basic_pixel_out", {20'd0, pixel_out}, 32'hF0F);
    chk("basic_pixel_valid", {31'd0, pixel_valid}, 32'd1);
    idle(2);

    // Transparency: single transparent word, then A,B,0,C stream
    step(1'b0, 1'b1, 2'd1, 16'd12, 1'b0);
    idle(2);
    chk("transp_valid", {31'd0, pixel_valid}, 32'd0);
    chk("transp_out", {20'd0, pixel_out}, 32'd0);
    for (int i = 10; i < 14; i++) step(1'b0, 1'b1, 2'd1, 16'(i), 1'b0);
    idle(3);

    // Address guard
    step(1'b0, 1'b1, 2'd2, 16'd1024, 1'b0);
    step(1'b0, 1'b1, 2'd2, 16'hFFF0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 2'd2, 16'd1023, 1'b0);
    idle(2);
    chk("addr1023_valid", {31'd0, pixel_valid}, 32'd1);
    idle(1);

    // Frame count: 10 opaque + 3 transparent
    step(1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    for (int i = 100; i < 113; i++) step(1'b0, 1'b1, 2'd0, 16'(i), 1'b0);
    step(1'b0, 1'b1, 2'd0, 16'd100, 1'b1);
    idle(2);
    chk("frame_count_10", {16'd0, frame_opaque}, 32'd10);
    step(1'b0, 1'b1, 2'd0, 16'd101, 1'b0);
    step(1'b0, 1'b1, 2'd0, 16'd102, 1'b0);
    step(1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(2);
    chk("frame_count_coincident", {16'd0, frame_opaque}, 32'd3);
    step(1'b0, 1'b1, 2'd0, 16'd103, 1'b1);
    step(1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(2);
    chk("frame_back_to_back", {16'd0, frame_opaque}, 32'd1);
    step(1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(2);
    chk("frame_empty", {16'd0, frame_opaque}, 32'd0);

    // Saturation
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 2'd3, 16'(i % 1024), 1'b0);
    step(1'b0, 1'b0, 2'd0, 16'd0, 1'b1);
    idle(2);
    chk("frame_saturate", {16'd0, frame_opaque}, 32'hFFFF);

    // Reset mid-stream with pixels in flight
    step(1'b0, 1'b1, 2'd3, 16'd7, 1'b0);
    step(1'b0, 1'b1, 2'd3, 16'd8, 1'b0);
    step(1'b0, 1'b1, 2'd3, 16'd9, 1'b0);
    step(1'b1, 1'b1, 2'd3, 16'd10, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 2'd2, 16'd5, 1'b0);
    idle(2);
    chk("post_rst_pixel", {20'd0, pixel_out}, 32'hF0F);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
